// File: rtl/chip8_mem_arbiter.sv
// Single-port CHIP-8 main memory arbiter: loader > CPU/GFX round robin, with a
// burst lock so one requester can own the port across multi-byte sequences.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gfx_req,
  input  logic              gfx_we,
  input  logic [ADDR_W-1:0] gfx_addr,
  input  logic [DATA_W-1:0] gfx_wdata,
  input  logic              gfx_lock,
  output logic              gfx_gnt,
  output logic              gfx_rvalid,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_OWN_LD  = 2'd1,
    ST_OWN_CPU = 2'd2,
    ST_OWN_GFX = 2'd3
  } state_t;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_LD   = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;
  localparam logic [1:0] TAG_GFX  = 2'd3;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rr_gfx;
  logic [2:0]        w_req;
  logic [2:0]        w_lock;
  logic [2:0]        w_gnt;
  logic [2:0]        w_own;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [1:0]        w_sel_tag;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_tag [RD_LAT+1];
  logic [2:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata [3];

  // Handshake: a transfer occurs in every cycle where req and gnt are both high;
  // the requester keeps req/we/addr/wdata/lock stable until that cycle.
  assign w_req  = {gfx_req, cpu_req, ld_req};
  assign w_lock = {gfx_lock, cpu_lock, ld_lock};

  always_comb begin
    w_gnt       = 3'b000;
    w_own       = 3'b000;
    w_state_nxt = r_state;
    case (r_state)
      ST_NONE: begin
        if (w_req[0])                             w_gnt = 3'b001;
        else if (w_req[1] && !(w_req[2] && r_rr_gfx)) w_gnt = 3'b010;
        else if (w_req[2])                        w_gnt = 3'b100;
      end
      ST_OWN_LD:  w_own = 3'b001;
      ST_OWN_CPU: w_own = 3'b010;
      ST_OWN_GFX: w_own = 3'b100;
      default:    w_own = 3'b000;
    endcase
    if (r_state != ST_NONE) begin
      // The owner leaves as soon as it drops lock, whether or not it transfers.
      w_gnt = w_req & w_own;
      if ((w_lock & w_own) == 3'b000) w_state_nxt = ST_NONE;
    end else if ((w_gnt & w_lock) != 3'b000) begin
      if (w_gnt[0])      w_state_nxt = ST_OWN_LD;
      else if (w_gnt[1]) w_state_nxt = ST_OWN_CPU;
      else               w_state_nxt = ST_OWN_GFX;
    end
    if (!reset_n) w_gnt = 3'b000;
  end

  always_comb begin
    w_sel_we    = ld_we;
    w_sel_addr  = ld_addr;
    w_sel_wdata = ld_wdata;
    w_sel_tag   = TAG_LD;
    if (w_gnt[1]) begin
      w_sel_we    = cpu_we;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
      w_sel_tag   = TAG_CPU;
    end else if (w_gnt[2]) begin
      w_sel_we    = gfx_we;
      w_sel_addr  = gfx_addr;
      w_sel_wdata = gfx_wdata;
      w_sel_tag   = TAG_GFX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_NONE;
      r_rr_gfx <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt[1])      r_rr_gfx <= 1'b1;
      else if (w_gnt[2]) r_rr_gfx <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_gnt != 3'b000) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= w_sel_we;
      r_mem_addr  <= w_sel_addr;
      r_mem_wdata <= w_sel_wdata;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // r_tag[0] travels with mem_en; r_tag[RD_LAT] lines up with valid mem_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= TAG_NONE;
      r_rvalid <= 3'b000;
      for (int i = 0; i < 3; i++) r_rdata[i] <= '0;
    end else begin
      r_tag[0] <= ((w_gnt != 3'b000) && !w_sel_we) ? w_sel_tag : TAG_NONE;
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_rvalid <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (r_tag[RD_LAT] == 2'(i + 1)) begin
          r_rvalid[i] <= 1'b1;
          r_rdata[i]  <= mem_rdata;
        end
      end
    end
  end

  assign ld_gnt     = w_gnt[0];
  assign cpu_gnt    = w_gnt[1];
  assign gfx_gnt    = w_gnt[2];
  assign ld_rvalid  = r_rvalid[0];
  assign cpu_rvalid = r_rvalid[1];
  assign gfx_rvalid = r_rvalid[2];
  assign ld_rdata   = r_rdata[0];
  assign cpu_rdata  = r_rdata[1];
  assign gfx_rdata  = r_rdata[2];
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same requester stimulus and are checked against a transaction-level model.
module tb_chip8_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    req, we, lock;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];

  logic [2:0]    gnt1, rvalid1, gnt3, rvalid3;
  logic [DW-1:0] rdata1 [3];
  logic [DW-1:0] rdata3 [3];
  logic          mem_en1, mem_we1, mem_en3, mem_we3;
  logic [AW-1:0] mem_addr1, mem_addr3;
  logic [DW-1:0] mem_wdata1, mem_wdata3, mem_rdata1, mem_rdata3;
  logic [1:0]    dbg1, dbg3;
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];

  always #5 clk = ~clk;

  chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .ld_req(req[0]), .ld_we(we[0]), .ld_addr(addr[0]), .ld_wdata(wdata[0]), .ld_lock(lock[0]),
    .ld_gnt(gnt1[0]), .ld_rvalid(rvalid1[0]), .ld_rdata(rdata1[0]),
    .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_lock(lock[1]),
    .cpu_gnt(gnt1[1]), .cpu_rvalid(rvalid1[1]), .cpu_rdata(rdata1[1]),
    .gfx_req(req[2]), .gfx_we(we[2]), .gfx_addr(addr[2]), .gfx_wdata(wdata[2]), .gfx_lock(lock[2]),
    .gfx_gnt(gnt1[2]), .gfx_rvalid(rvalid1[2]), .gfx_rdata(rdata1[2]),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .dbg_state(dbg1)
  );

  chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .ld_req(req[0]), .ld_we(we[0]), .ld_addr(addr[0]), .ld_wdata(wdata[0]), .ld_lock(lock[0]),
    .ld_gnt(gnt3[0]), .ld_rvalid(rvalid3[0]), .ld_rdata(rdata3[0]),
    .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_lock(lock[1]),
    .cpu_gnt(gnt3[1]), .cpu_rvalid(rvalid3[1]), .cpu_rdata(rdata3[1]),
    .gfx_req(req[2]), .gfx_we(we[2]), .gfx_addr(addr[2]), .gfx_wdata(wdata[2]), .gfx_lock(lock[2]),
    .gfx_gnt(gnt3[2]), .gfx_rvalid(rvalid3[2]), .gfx_rdata(rdata3[2]),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .dbg_state(dbg3)
  );

  // Memory content is a fixed function of the address; 0x200 reads 0xA2.
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h80;
  endfunction

  // Latency-1 and latency-3 memories; garbage on the bus when nothing was read.
  always @(posedge clk) begin
    pipe1    <= (mem_en1 && !mem_we1) ? mem_f(mem_addr1) : 8'($urandom);
    pipe3[0] <= (mem_en3 && !mem_we3) ? mem_f(mem_addr3) : 8'($urandom);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3[2];

  // ---------------- reference model and scoreboard ----------------
  int            cyc, vectors, miscompares;
  int            m_owner;
  bit            m_pref_gfx;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] exp_rd1 [3];
  logic [DW-1:0] exp_rd3 [3];
  logic [25:0]   exp_q1[$];   // {due_cycle[15:0], port[1:0], data[7:0]}
  logic [25:0]   exp_q3[$];
  logic [2:0]    last_gnt, s_gnt1;
  logic [1:0]    s_state1;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] gnt;
    int         st;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_pref_gfx = 1'b0;
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      exp_rd1[i] = '0;
      exp_rd3[i] = '0;
    end
    exp_q1.delete();
    exp_q3.delete();
  endtask

  function automatic logic [2:0] model_gnt();
    if (!reset_n) return 3'b000;
    if (m_owner >= 0) return req[m_owner] ? 3'(1 << m_owner) : 3'b000;
    if (req[0]) return 3'b001;
    if (req[1] && req[2]) return m_pref_gfx ? 3'b100 : 3'b010;
    if (req[1]) return 3'b010;
    if (req[2]) return 3'b100;
    return 3'b000;
  endfunction

  // One clock: check at negedge, advance the model at posedge, return at posedge+1.
  task automatic tick();
    logic [2:0] eg, ev1, ev3;
    int p;
    int exp_state;
    @(negedge clk);
    eg  = model_gnt();
    ev1 = 3'b000;
    ev3 = 3'b000;
    if (exp_q1.size() > 0 && exp_q1[0][25:10] == 16'(cyc)) begin
      ev1[exp_q1[0][9:8]]     = 1'b1;
      exp_rd1[exp_q1[0][9:8]] = exp_q1[0][7:0];
      void'(exp_q1.pop_front());
    end
    if (exp_q3.size() > 0 && exp_q3[0][25:10] == 16'(cyc)) begin
      ev3[exp_q3[0][9:8]]     = 1'b1;
      exp_rd3[exp_q3[0][9:8]] = exp_q3[0][7:0];
      void'(exp_q3.pop_front());
    end
    exp_state = (m_owner < 0) ? 0 : m_owner + 1;
    chk("gnt_l1", gnt1, eg);
    chk("gnt_l3", gnt3, eg);
    chk("state_l1", dbg1, exp_state);
    chk("state_l3", dbg3, exp_state);
    chk("mem_en_l1", mem_en1, m_en);
    chk("mem_en_l3", mem_en3, m_en);
    chk("mem_we_l1", mem_we1, m_we);
    chk("mem_we_l3", mem_we3, m_we);
    chk("mem_addr_l1", mem_addr1, m_addr);
    chk("mem_addr_l3", mem_addr3, m_addr);
    chk("mem_wdata_l1", mem_wdata1, m_wdata);
    chk("mem_wdata_l3", mem_wdata3, m_wdata);
    chk("rvalid_l1", rvalid1, ev1);
    chk("rvalid_l3", rvalid3, ev3);
    for (int i = 0; i < 3; i++) begin
      chk("rdata_l1", rdata1[i], exp_rd1[i]);
      chk("rdata_l3", rdata3[i], exp_rd3[i]);
    end
    s_gnt1   = gnt1;
    s_state1 = dbg1;
    last_gnt = eg;
    @(posedge clk);
    if (reset_n) begin
      if (eg != 3'b000) begin
        p = eg[0] ? 0 : (eg[1] ? 1 : 2);
        m_en = 1'b1; m_we = we[p]; m_addr = addr[p]; m_wdata = wdata[p];
        if (!we[p]) begin
          exp_q1.push_back({16'(cyc + 3), 2'(p), mem_f(addr[p])});
          exp_q3.push_back({16'(cyc + 5), 2'(p), mem_f(addr[p])});
        end
        if (p == 1) m_pref_gfx = 1'b1;
        else if (p == 2) m_pref_gfx = 1'b0;
        if (m_owner < 0) begin
          if (lock[p]) m_owner = p;
        end else if (!lock[p]) begin
          m_owner = -1;
        end
      end else begin
        m_en = 1'b0;
        m_we = 1'b0;
        if (m_owner >= 0 && !lock[m_owner]) m_owner = -1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) tick();
    reset_n = 1'b1;
  endtask

  task automatic new_txn(input int p);
    req[p]   = 1'b1;
    we[p]    = 1'($urandom_range(0, 1));
    addr[p]  = 12'($urandom);
    wdata[p] = 8'($urandom);
    lock[p]  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    reset_n = 1'b0;
    req = 3'b111; we = 3'b000; lock = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 12'(16 * i + 1);
      wdata[i] = '0;
    end
    model_reset();

    // Reset held with every port requesting, then loader wins the first cycle.
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_first_gnt", s_gnt1, 3'b001);
    req = 3'b000;
    repeat (5) tick();

    // Grant/ownership vectors ({gfx,cpu,ld}), applied from a fresh reset.
    tbl[0]  = '{3'b111, 3'b000, 3'b001, 0};
    tbl[1]  = '{3'b110, 3'b000, 3'b010, 0};
    tbl[2]  = '{3'b110, 3'b000, 3'b100, 0};
    tbl[3]  = '{3'b100, 3'b000, 3'b100, 0};
    tbl[4]  = '{3'b110, 3'b000, 3'b010, 0};
    tbl[5]  = '{3'b010, 3'b010, 3'b010, 0};
    tbl[6]  = '{3'b101, 3'b010, 3'b000, 2};
    tbl[7]  = '{3'b111, 3'b010, 3'b010, 2};
    tbl[8]  = '{3'b111, 3'b000, 3'b010, 2};
    tbl[9]  = '{3'b111, 3'b000, 3'b001, 0};
    tbl[10] = '{3'b110, 3'b000, 3'b100, 0};
    tbl[11] = '{3'b000, 3'b100, 3'b000, 0};
    tbl[12] = '{3'b100, 3'b100, 3'b100, 0};
    tbl[13] = '{3'b011, 3'b100, 3'b000, 3};
    tbl[14] = '{3'b011, 3'b000, 3'b000, 3};
    tbl[15] = '{3'b011, 3'b000, 3'b001, 0};
    tbl[16] = '{3'b010, 3'b000, 3'b010, 0};
    tbl[17] = '{3'b001, 3'b001, 3'b001, 0};
    tbl[18] = '{3'b110, 3'b001, 3'b000, 1};
    tbl[19] = '{3'b111, 3'b000, 3'b001, 1};
    tbl[20] = '{3'b110, 3'b000, 3'b100, 0};
    apply_reset(1);
    we = 3'b111;
    for (int i = 0; i < 21; i++) begin
      req  = tbl[i].req;
      lock = tbl[i].lock;
      for (int k = 0; k < 3; k++) begin
        addr[k]  = 12'(3 * i + k);
        wdata[k] = 8'(i + 16 * k);
      end
      tick();
      chk("tbl_gnt", s_gnt1, tbl[i].gnt);
      chk("tbl_state", s_state1, tbl[i].st);
    end
    req = 3'b000; lock = 3'b000; we = 3'b000;
    repeat (2) tick();

    // Single CPU read of 0x200.
    addr[1] = 12'h200;
    req = 3'b010;
    tick();
    req = 3'b000;
    repeat (5) tick();
    chk("single_rdata_l1", rdata1[1], 8'hA2);
    chk("single_rdata_l3", rdata3[1], 8'hA2);

    // Round robin: CPU and GFX each issue three reads back to back.
    begin
      int cnt [3];
      for (int p = 0; p < 3; p++) cnt[p] = 0;
      addr[1] = 12'h210; addr[2] = 12'h220;
      req = 3'b110;
      for (int i = 0; i < 20 && req != 3'b000; i++) begin
        tick();
        for (int p = 1; p < 3; p++) begin
          if (last_gnt[p]) begin
            cnt[p]++;
            addr[p] = addr[p] + 12'd1;
            if (cnt[p] >= 3) req[p] = 1'b0;
          end
        end
      end
      chk("rr_cpu_count", cnt[1], 3);
      chk("rr_gfx_count", cnt[2], 3);
    end
    repeat (7) tick();

    // Locked 16-byte CPU write burst with loader and GFX waiting.
    addr[0] = 12'h050; addr[2] = 12'h060;
    we = 3'b010;
    req = 3'b010;
    for (int i = 0; i < 16; i++) begin
      addr[1]  = 12'h300 + 12'(i);
      wdata[1] = 8'(8'hC0 + i);
      lock[1]  = (i != 15);
      tick();
      chk("burst_cpu_gnt", s_gnt1, 3'b010);
      req = 3'b111;
    end
    req[1] = 1'b0; lock[1] = 1'b0;
    tick();
    chk("burst_then_ld", s_gnt1, 3'b001);
    req[0] = 1'b0;
    tick();
    chk("burst_then_gfx", s_gnt1, 3'b100);
    req = 3'b000; we = 3'b000;
    repeat (7) tick();

    // All three read at once; each drops its request once served.
    addr[0] = 12'h0A0; addr[1] = 12'h1B1; addr[2] = 12'h2C2;
    req = 3'b111;
    for (int i = 0; i < 10 && req != 3'b000; i++) begin
      tick();
      req = req & ~last_gnt;
    end
    req = 3'b000;
    repeat (8) tick();

    // Reset one cycle after a GFX read grant; then a CPU read completes.
    addr[2] = 12'h2AB;
    req = 3'b100;
    tick();
    req = 3'b000;
    apply_reset(2);
    addr[1] = 12'h345;
    req = 3'b010;
    tick();
    req = 3'b000;
    repeat (7) tick();
    chk("rst_cpu_rdata", rdata1[1], 8'hF6);
    chk("rst_gfx_rdata", rdata1[2], 8'h00);

    // Randomized traffic with locks, idle-with-lock and abandoned requests.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) apply_reset(2);
      tick();
      for (int p = 0; p < 3; p++) begin
        if (req[p] && last_gnt[p]) begin
          if ($urandom_range(0, 9) < 6) new_txn(p);
          else begin
            req[p] = 1'b0;
            if ($urandom_range(0, 1) == 0) lock[p] = 1'b0;
          end
        end else if (req[p]) begin
          if ($urandom_range(0, 31) == 0) begin
            req[p]  = 1'b0;
            lock[p] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 3) begin
          new_txn(p);
        end else if (lock[p] && $urandom_range(0, 3) == 0) begin
          lock[p] = 1'b0;
        end
      end
    end
    req = 3'b000; lock = 3'b000;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
